// File: rtl/cla_sum_accumulator.sv
// Sums a programmed number of CLA32 results over valid/ready and holds the total until it is taken.
// The overflow flag is sticky for the run and records any carry out of the accumulator.
module cla_sum_accumulator #(
  parameter int IN_W  = 33,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [ACC_W:0]   sum_w;
  logic             xfer_w;

  // The extra top bit of the result is the carry out of the accumulator width.
  function automatic logic [ACC_W:0] add_zext(input logic [ACC_W-1:0] acc,
                                              input logic [IN_W-1:0]  din);
    logic [ACC_W:0] a_ext;
    logic [ACC_W:0] d_ext;
    a_ext = {1'b0, acc};
    d_ext = {{(ACC_W + 1 - IN_W){1'b0}}, din};
    return a_ext + d_ext;
  endfunction

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

  assign xfer_w = in_valid & in_ready;
  assign sum_w  = add_zext(acc_q, in_data);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          len_d   = len;
          state_d = (len != '0) ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        if (xfer_w) begin
          acc_d = sum_w[ACC_W-1:0];
          ovf_d = ovf_q | sum_w[ACC_W];
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == len_q - CNT_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A start arriving together with out_ready is dropped: only IDLE samples start.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_cla_sum_accumulator.sv
// Directed and soak bench for cla_sum_accumulator; a 40-bit and a 33-bit instance run in lockstep.
module tb_cla_sum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [32:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf, busy;
  logic [39:0] out_data;
  logic        in_ready33, out_valid33, out_ovf33, busy33;
  logic [32:0] out_data33;

  int n_cmp;
  int n_bad;

  cla_sum_accumulator #(.IN_W(33), .ACC_W(40), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  cla_sum_accumulator #(.IN_W(33), .ACC_W(33), .CNT_W(8)) dut33 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready33),
    .out_data(out_data33), .out_ovf(out_ovf33), .out_valid(out_valid33),
    .out_ready(out_ready), .busy(busy33)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Presents one sum and waits (bounded) for it to be accepted.
  task automatic feed(input logic [32:0] d);
    int waited;
    waited   = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && waited < 30) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL feed_timeout: in_ready=%b after %0d cycles, need 1", in_ready, waited);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    n_cmp++;
    if ({in_ready, out_valid, busy, out_ovf} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b need 0000", {in_ready, out_valid, busy, out_ovf});
    end
    n_cmp++;
    if (out_data !== 40'h0) begin
      n_bad++; $display("FAIL reset_data: got %h need 0", out_data);
    end
    n_cmp++;
    if ({in_ready33, out_valid33, busy33, out_ovf33} !== 4'b0000 || out_data33 !== 33'h0) begin
      n_bad++; $display("FAIL reset_dut33: ctrl %b data %h need 0", {in_ready33, out_valid33, busy33, out_ovf33}, out_data33);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL idle_no_start: busy=%b in_ready=%b out_valid=%b need 0", busy, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_basic();
    start_run(8'd3);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL basic_acc_entry: in_ready=%b busy=%b need 1 1", in_ready, busy);
    end
    feed(33'h0_0000_0001);
    feed(33'h0_0000_0002);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_early_valid: out_valid=%b need 0", out_valid);
    end
    feed(33'h1_FFFF_FFFF);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL basic_latency: out_valid=%b in_ready=%b need 1 0", out_valid, in_ready);
    end
    n_cmp++;
    if (out_data !== 40'h02_0000_0002 || out_ovf !== 1'b0) begin
      n_bad++; $display("FAIL basic_sum: got %h ovf %b need 0200000002 ovf 0", out_data, out_ovf);
    end
    n_cmp++;
    if (out_data33 !== 33'h0_0000_0002 || out_ovf33 !== 1'b1) begin
      n_bad++; $display("FAIL basic_sum33: got %h ovf %b need 000000002 ovf 1", out_data33, out_ovf33);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_release: busy=%b out_valid=%b need 0 0", busy, out_valid);
    end
  endtask

  task automatic test_len0();
    start_run(8'd0);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL len0_state: out_valid=%b in_ready=%b busy=%b need 1 0 1", out_valid, in_ready, busy);
    end
    n_cmp++;
    if (out_data !== 40'h0 || out_ovf !== 1'b0 || out_ovf33 !== 1'b0) begin
      n_bad++; $display("FAIL len0_data: got %h ovf %b ovf33 %b need 0 0 0", out_data, out_ovf, out_ovf33);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL len0_release: busy=%b need 0", busy);
    end
  endtask

  task automatic test_ovf33();
    start_run(8'd2);
    feed(33'h1_FFFF_FFFF);
    feed(33'h1_FFFF_FFFF);
    n_cmp++;
    if (out_data33 !== 33'h1_FFFF_FFFE || out_ovf33 !== 1'b1) begin
      n_bad++; $display("FAIL ovf33: got %h ovf %b need 1fffffffe ovf 1", out_data33, out_ovf33);
    end
    n_cmp++;
    if (out_data !== 40'h03_FFFF_FFFE || out_ovf !== 1'b0) begin
      n_bad++; $display("FAIL ovf40: got %h ovf %b need 03fffffffe ovf 0", out_data, out_ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [32:0] vals [4];
    int          gaps [4];
    vals = '{33'd5, 33'd10, 33'd20, 33'd40};
    gaps = '{0, 2, 1, 3};
    start_run(8'd4);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        start = (g == 0);
        len   = 8'd1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          n_bad++; $display("FAIL gap_hold: in_ready=%b out_valid=%b need 1 0", in_ready, out_valid);
        end
      end
      feed(vals[k]);
    end
    for (int c = 0; c < 5; c++) begin
      start    = (c == 1);
      len      = 8'd1;
      in_valid = 1'b1;
      in_data  = 33'h0_DEAD_BEEF;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 40'd75 || out_ovf !== 1'b0) begin
        n_bad++; $display("FAIL bp_stable: valid=%b in_ready=%b data=%h ovf=%b need 1 0 4b 0", out_valid, in_ready, out_data, out_ovf);
      end
      tick();
    end
    in_valid  = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL start_lost: busy=%b need 0", busy);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || out_data !== 40'd75) begin
      n_bad++; $display("FAIL idle_after_lost_start: busy=%b data=%h need 0 4b", busy, out_data);
    end
  endtask

  task automatic test_reset_mid();
    start_run(8'd4);
    feed(33'd3);
    feed(33'd4);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 40'h0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: busy=%b in_ready=%b data=%h valid=%b need 0 0 0 0", busy, in_ready, out_data, out_valid);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL reset_mid_quiet: valid=%b busy=%b need 0 0", out_valid, busy);
      end
    end
    start_run(8'd1);
    feed(33'd7);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 40'd7 || out_data33 !== 33'd7) begin
      n_bad++; $display("FAIL reset_mid_rerun: valid=%b data=%h data33=%h need 1 7 7", out_valid, out_data, out_data33);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_soak();
    logic [31:0] a, b;
    logic [32:0] s;
    logic [63:0] total;
    logic [33:0] acc33;
    logic        c33;
    int          l;
    for (int run = 0; run < 100; run++) begin
      l     = $urandom_range(20, 1);
      total = '0;
      acc33 = '0;
      c33   = 1'b0;
      start_run(8'(l));
      for (int k = 0; k < l; k++) begin
        a = $urandom;
        b = $urandom;
        s = {1'b0, a} + {1'b0, b};
        total = total + 64'(s);
        acc33 = {1'b0, acc33[32:0]} + {1'b0, s};
        c33   = c33 | acc33[33];
        if ($urandom_range(3, 0) == 0) tick();
        feed(s);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== total[39:0] || out_ovf !== (total >= 64'h100_0000_0000)) begin
        n_bad++; $display("FAIL soak40 run %0d: valid=%b data=%h ovf=%b need 1 %h %b", run, out_valid, out_data, out_ovf, total[39:0], (total >= 64'h100_0000_0000));
      end
      n_cmp++;
      if (out_data33 !== acc33[32:0] || out_ovf33 !== c33) begin
        n_bad++; $display("FAIL soak33 run %0d: data=%h ovf=%b need %h %b", run, out_data33, out_ovf33, acc33[32:0], c33);
      end
      for (int w = $urandom_range(2, 0); w > 0; w--) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_len0();
    test_ovf33();
    test_backpressure();
    test_reset_mid();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
